exc_redirect_ctrl: RTL and testbench

- Exception/interrupt controller for the 5-stage MIPS pipeline; holds the SR, Cause, EPC and PRId registers.
- Sits beside pc_F and the M stage. It decides when fetch is redirected to the handler, or back to EPC on eret, and flushes younger stages.
- Drives pc_F's exp_in and epc inputs, plus a forced PC enable so a redirect overrides a stall.

---
 rtl/exc_redirect_ctrl_pkg.sv | 33 +++
 rtl/exc_redirect_ctrl_cp0_timer.sv | 56 +++++
 rtl/exc_redirect_ctrl.sv | 156 +++++++++++++++
 tb/tb_exc_redirect_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exc_redirect_ctrl_pkg.sv
// Shared definitions for the exception/redirect controller: CP0 register
// numbers, exception codes, handler entry address, FSM state encodings and
// the EPC selection helper.
package exc_redirect_ctrl_pkg;

  // CP0 register numbers
  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_SR      = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;
  localparam logic [4:0] CP0_PRID    = 5'd15;

  // ExcCode values
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // Handler entry; pc_F uses the same value when exp_in is high
  localparam logic [31:0] HANDLER_ADDR_DEF = 32'h0000_4180;

  // FSM encodings: the state bit is SR.EXL
  localparam logic [0:0] ST_NORMAL  = 1'b0;
  localparam logic [0:0] ST_HANDLER = 1'b1;

  // A delay-slot instruction restarts at its branch, one word earlier
  function automatic logic [31:0] epc_from_slot(input logic [31:0] pc, input logic bd);
    return bd ? (pc - 32'd4) : pc;
  endfunction

endpackage

// File: rtl/exc_redirect_ctrl_cp0_timer.sv
// CP0 Count/Compare timer. Only built when EXC_TIMER_EN is defined.
// Count increments every cycle unless written; pending latches on
// Count == Compare and is cleared by writing Compare.
`ifdef EXC_TIMER_EN
module exc_redirect_ctrl_cp0_timer (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        wr_count_i,
  input  logic        wr_compare_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        pending_o
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        pending_q, pending_d;

  // Next-state for count, compare and the pending flag
  always_comb begin
    count_d   = count_q + 32'd1;
    compare_d = compare_q;
    pending_d = pending_q | (count_q == compare_q);
    if (wr_count_i) begin
      count_d = wdata_i;
    end else begin
      count_d = count_q + 32'd1;
    end
    if (wr_compare_i) begin
      compare_d = wdata_i;
      pending_d = 1'b0;
    end else begin
      compare_d = compare_q;
    end
  end

  // Timer state registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      count_q   <= 32'd0;
      compare_q <= 32'd0;
      pending_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      pending_q <= pending_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign pending_o = pending_q;

endmodule
`endif

// File: rtl/exc_redirect_ctrl.sv
// Exception/interrupt redirect controller for the 5-stage pipeline.
// Holds SR, Cause, EPC and PRId; redirects fetch to the handler or back
// to EPC on eret, and flushes the younger stages.
// Optional Count/Compare timer enabled by defining EXC_TIMER_EN.
module exc_redirect_ctrl
  import exc_redirect_ctrl_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = HANDLER_ADDR_DEF,
  parameter logic [31:0] PRID_VAL     = 32'h2019_0001
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] pc_M,
  input  logic        bd_M,
  input  logic [4:0]  exc_code_M,
  input  logic        eret_M,
  input  logic [5:0]  hw_int,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  output logic        exp_in,
  output logic        eret_go,
  output logic        pc_force_en,
  output logic        flush,
  output logic [31:0] epc,
  output logic        exl
);

  logic [0:0]  state_q, state_d;
  logic [5:0]  im_q, im_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [4:0]  code_q, code_d;
  logic [31:0] epc_q, epc_d;
  logic [5:0]  ip_q;

  logic [5:0]  ip_eff_s;
  logic        int_req_s;
  logic        take_s;
  logic        eret_go_s;
  logic        wr_en_s;
  logic        timer_pend_s;
  logic        unused_handler_s;

  // The handler address is consumed by pc_F; kept here for a single source
  assign unused_handler_s = ^HANDLER_ADDR;

`ifdef EXC_TIMER_EN
  logic [31:0] count_s;
  logic [31:0] compare_s;

  exc_redirect_ctrl_cp0_timer u_timer (
    .Clk          (Clk),
    .Reset        (Reset),
    .wr_count_i   (wr_en_s && (cp0_addr == CP0_COUNT)),
    .wr_compare_i (wr_en_s && (cp0_addr == CP0_COMPARE)),
    .wdata_i      (cp0_wdata),
    .count_o      (count_s),
    .compare_o    (compare_s),
    .pending_o    (timer_pend_s)
  );
`else
  assign timer_pend_s = 1'b0;
`endif

  // Event decode: interrupt and sync exception share one redirect path
  always_comb begin
    ip_eff_s  = ip_q | {timer_pend_s, 5'b00000};
    int_req_s = ie_q & (state_q == ST_NORMAL) & (|(ip_eff_s & im_q));
    take_s    = ~Reset & (int_req_s | (exc_code_M != EXC_INT));
    eret_go_s = ~Reset & eret_M & ~take_s;
    wr_en_s   = ~Reset & cp0_we & ~take_s & ~eret_go_s;
  end

  // Next-state for SR/Cause/EPC by event priority
  always_comb begin
    state_d = state_q;
    im_d    = im_q;
    ie_d    = ie_q;
    bd_d    = bd_q;
    code_d  = code_q;
    epc_d   = epc_q;
    if (take_s) begin
      code_d  = int_req_s ? EXC_INT : exc_code_M;
      state_d = ST_HANDLER;
      if (state_q == ST_NORMAL) begin
        epc_d = epc_from_slot(pc_M, bd_M);
        bd_d  = bd_M;
      end else begin
        epc_d = epc_q;
        bd_d  = bd_q;
      end
    end else if (eret_go_s) begin
      state_d = ST_NORMAL;
    end else if (wr_en_s) begin
      case (cp0_addr)
        CP0_SR: begin
          im_d    = cp0_wdata[15:10];
          state_d = cp0_wdata[1] ? ST_HANDLER : ST_NORMAL;
          ie_d    = cp0_wdata[0];
        end
        CP0_EPC: epc_d = cp0_wdata;
        default: epc_d = epc_q;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // CP0 state registers; Cause.IP samples hw_int every cycle
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_NORMAL;
      im_q    <= 6'd0;
      ie_q    <= 1'b0;
      bd_q    <= 1'b0;
      code_q  <= 5'd0;
      epc_q   <= 32'd0;
      ip_q    <= 6'd0;
    end else begin
      state_q <= state_d;
      im_q    <= im_d;
      ie_q    <= ie_d;
      bd_q    <= bd_d;
      code_q  <= code_d;
      epc_q   <= epc_d;
      ip_q    <= hw_int;
    end
  end

  // mfc0 read mux, current register values only
  always_comb begin
    cp0_rdata = 32'd0;
    case (cp0_addr)
      CP0_SR:    cp0_rdata = {16'h0000, im_q, 8'h00, state_q, ie_q};
      CP0_CAUSE: cp0_rdata = {bd_q, 15'h0000, ip_eff_s, 3'b000, code_q, 2'b00};
      CP0_EPC:   cp0_rdata = epc_q;
      CP0_PRID:  cp0_rdata = PRID_VAL;
`ifdef EXC_TIMER_EN
      CP0_COUNT:   cp0_rdata = count_s;
      CP0_COMPARE: cp0_rdata = compare_s;
`endif
      default:   cp0_rdata = 32'd0;
    endcase
  end

  // Redirect controls; register views forced to 0 during reset
  assign exp_in      = take_s;
  assign eret_go     = eret_go_s;
  assign pc_force_en = take_s | eret_go_s;
  assign flush       = take_s | eret_go_s;
  assign epc         = Reset ? 32'd0 : epc_q;
  assign exl         = Reset ? 1'b0 : (state_q == ST_HANDLER);

endmodule

// File: tb/tb_exc_redirect_ctrl.sv
// Self-checking bench for exc_redirect_ctrl: directed scenarios with
// literal expectations, then randomized traffic compared every cycle
// against a behavioural model of the CP0 rules.
module tb_exc_redirect_ctrl;

  logic        Clk;
  logic        Reset;
  logic [31:0] pc_M;
  logic        bd_M;
  logic [4:0]  exc_code_M;
  logic        eret_M;
  logic [5:0]  hw_int;
  logic        cp0_we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic        exp_in, eret_go, pc_force_en, flush, exl;
  logic [31:0] epc;

  int checks = 0;
  int errors = 0;

  exc_redirect_ctrl dut (
    .Clk(Clk), .Reset(Reset), .pc_M(pc_M), .bd_M(bd_M), .exc_code_M(exc_code_M),
    .eret_M(eret_M), .hw_int(hw_int), .cp0_we(cp0_we), .cp0_addr(cp0_addr),
    .cp0_wdata(cp0_wdata), .cp0_rdata(cp0_rdata), .exp_in(exp_in), .eret_go(eret_go),
    .pc_force_en(pc_force_en), .flush(flush), .epc(epc), .exl(exl)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Behavioural model of the architectural CP0 state
  logic [5:0]  m_im, m_ip;
  logic        m_ie, m_exl, m_bd, m_pend;
  logic [4:0]  m_code;
  logic [31:0] m_epc, m_count, m_cmp;

  initial begin
    m_im = 6'd0; m_ip = 6'd0; m_ie = 1'b0; m_exl = 1'b0; m_bd = 1'b0;
    m_code = 5'd0; m_epc = 32'd0; m_count = 32'd0; m_cmp = 32'd0; m_pend = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] m_ip_eff();
`ifdef EXC_TIMER_EN
    return m_ip | (m_pend ? 6'b100000 : 6'b000000);
`else
    return m_ip;
`endif
  endfunction

  function automatic logic m_int();
    return m_ie && !m_exl && ((m_ip_eff() & m_im) != 6'd0);
  endfunction

  function automatic logic m_take();
    return !Reset && (m_int() || (exc_code_M != 5'd0));
  endfunction

  function automatic logic m_eret();
    return !Reset && eret_M && !m_take();
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12: return (32'(m_im) << 10) | (32'(m_exl) << 1) | 32'(m_ie);
      5'd13: return (32'(m_bd) << 31) | (32'(m_ip_eff()) << 10) | (32'(m_code) << 2);
      5'd14: return m_epc;
      5'd15: return 32'h2019_0001;
`ifdef EXC_TIMER_EN
      5'd9:  return m_count;
      5'd11: return m_cmp;
`endif
      default: return 32'd0;
    endcase
  endfunction

  // Model update at each active edge from the pre-edge state
  always @(posedge Clk) begin
    logic        tk, eg, wr, intr;
    logic [5:0]  n_im;
    logic        n_ie, n_exl, n_bd, n_pend;
    logic [4:0]  n_code;
    logic [31:0] n_epc, n_count, n_cmp;
    tk = m_take(); eg = m_eret(); intr = m_int();
    wr = !Reset && cp0_we && !tk && !eg;
    n_im = m_im; n_ie = m_ie; n_exl = m_exl; n_bd = m_bd; n_code = m_code; n_epc = m_epc;
    n_count = (wr && cp0_addr == 5'd9) ? cp0_wdata : m_count + 32'd1;
    n_cmp   = (wr && cp0_addr == 5'd11) ? cp0_wdata : m_cmp;
    n_pend  = (wr && cp0_addr == 5'd11) ? 1'b0 : (m_pend || (m_count == m_cmp));
    if (tk) begin
      n_code = intr ? 5'd0 : exc_code_M;
      if (!m_exl) begin
        n_epc = bd_M ? pc_M - 32'd4 : pc_M;
        n_bd  = bd_M;
      end
      n_exl = 1'b1;
    end else if (eg) begin
      n_exl = 1'b0;
    end else if (wr && cp0_addr == 5'd12) begin
      n_im = cp0_wdata[15:10]; n_exl = cp0_wdata[1]; n_ie = cp0_wdata[0];
    end else if (wr && cp0_addr == 5'd14) begin
      n_epc = cp0_wdata;
    end
    if (Reset) begin
      m_im <= 6'd0; m_ip <= 6'd0; m_ie <= 1'b0; m_exl <= 1'b0; m_bd <= 1'b0;
      m_code <= 5'd0; m_epc <= 32'd0; m_count <= 32'd0; m_cmp <= 32'd0; m_pend <= 1'b0;
    end else begin
      m_im <= n_im; m_ip <= hw_int; m_ie <= n_ie; m_exl <= n_exl; m_bd <= n_bd;
      m_code <= n_code; m_epc <= n_epc; m_count <= n_count; m_cmp <= n_cmp; m_pend <= n_pend;
    end
  end

  // Per-cycle comparison of every DUT output against the model
  always begin
    @(negedge Clk);
    #3;
    chk("exp_in", 32'(exp_in), 32'(m_take()));
    chk("eret_go", 32'(eret_go), 32'(m_eret()));
    chk("flush", 32'(flush), 32'(m_take() || m_eret()));
    chk("pc_force_en", 32'(pc_force_en), 32'(m_take() || m_eret()));
    chk("epc", epc, Reset ? 32'd0 : m_epc);
    chk("exl", 32'(exl), Reset ? 32'd0 : 32'(m_exl));
    if (!Reset) chk("cp0_rdata", cp0_rdata, m_read(cp0_addr));
  end

  task automatic idle();
    Reset = 1'b0; pc_M = 32'h0000_3000; bd_M = 1'b0; exc_code_M = 5'd0; eret_M = 1'b0;
    hw_int = 6'd0; cp0_we = 1'b0; cp0_addr = 5'd0; cp0_wdata = 32'd0;
  endtask

  task automatic rd(input string name, input logic [4:0] a, input logic [31:0] exp);
    cp0_addr = a;
    #1;
    chk(name, cp0_rdata, exp);
  endtask

  initial begin
    idle();
    Reset = 1'b1; exc_code_M = 5'd12; eret_M = 1'b1;
    #1;
    chk("rst_exp_in", 32'(exp_in), 32'd0);
    chk("rst_eret_go", 32'(eret_go), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_epc", epc, 32'd0);
    @(negedge Clk);
    @(negedge Clk);
    idle();
    rd("rst_sr", 5'd12, 32'd0);
    rd("rst_cause", 5'd13, 32'd0);
    rd("rst_epc_rd", 5'd14, 32'd0);
    rd("prid", 5'd15, 32'h2019_0001);
    chk("idle_exp_in", 32'(exp_in), 32'd0);
    @(negedge Clk);

    // Overflow exception from NORMAL
    exc_code_M = 5'd12; pc_M = 32'h0000_3010;
    #1;
    chk("ov_exp_in", 32'(exp_in), 32'd1);
    chk("ov_flush", 32'(flush), 32'd1);
    chk("ov_force", 32'(pc_force_en), 32'd1);
    @(negedge Clk);
    idle();
    rd("ov_epc", 5'd14, 32'h0000_3010);
    rd("ov_cause", 5'd13, 32'h0000_0030);
    chk("ov_exl", 32'(exl), 32'd1);
    @(negedge Clk);

    // eret from HANDLER
    eret_M = 1'b1;
    #1;
    chk("eret_go", 32'(eret_go), 32'd1);
    chk("eret_flush", 32'(flush), 32'd1);
    @(negedge Clk);
    idle();
    #1;
    chk("eret_exl", 32'(exl), 32'd0);

    // Interrupt taken from a delay slot
    cp0_we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0401;
    @(negedge Clk);
    idle(); hw_int = 6'b000001; pc_M = 32'h0000_3020;
    #1;
    chk("int_latency", 32'(exp_in), 32'd0);
    @(negedge Clk);
    hw_int = 6'b000001; bd_M = 1'b1; pc_M = 32'h0000_3024;
    #1;
    chk("int_exp_in", 32'(exp_in), 32'd1);
    @(negedge Clk);
    idle();
    rd("int_epc", 5'd14, 32'h0000_3020);
    rd("int_cause", 5'd13, 32'h8000_0400);
    @(negedge Clk);

    // Nested exception keeps EPC/BD
    exc_code_M = 5'd10; pc_M = 32'h0000_5000;
    #1;
    chk("nest_exp_in", 32'(exp_in), 32'd1);
    @(negedge Clk);
    idle();
    rd("nest_epc", 5'd14, 32'h0000_3020);
    rd("nest_cause", 5'd13, 32'h8000_0028);
    @(negedge Clk);
    eret_M = 1'b1;
    @(negedge Clk);

    // Exception beats a simultaneous mtc0 to EPC
    idle(); exc_code_M = 5'd4; pc_M = 32'h0000_0100;
    cp0_we = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'hDEAD_BEEF;
    #1;
    chk("sim_exp_in", 32'(exp_in), 32'd1);
    @(negedge Clk);
    idle();
    rd("sim_epc", 5'd14, 32'h0000_0100);
    rd("sim_cause", 5'd13, 32'h0000_0010);
    @(negedge Clk);
    eret_M = 1'b1;
    @(negedge Clk);

    // EPC wraps for a delay slot at address 0
    idle(); exc_code_M = 5'd5; pc_M = 32'd0; bd_M = 1'b1;
    @(negedge Clk);
    idle();
    rd("wrap_epc", 5'd14, 32'hFFFF_FFFC);
    @(negedge Clk);
    eret_M = 1'b1;
    @(negedge Clk);

    // eret in NORMAL still honoured; PRId write ignored
    idle(); eret_M = 1'b1;
    #1;
    chk("eret_normal", 32'(eret_go), 32'd1);
    @(negedge Clk);
    idle(); cp0_we = 1'b1; cp0_addr = 5'd15; cp0_wdata = 32'd0;
    @(negedge Clk);
    idle();
    rd("prid_ro", 5'd15, 32'h2019_0001);
    @(negedge Clk);

`ifdef EXC_TIMER_EN
    begin
      logic hit;
      idle(); Reset = 1'b1;
      @(negedge Clk);
      idle(); cp0_we = 1'b1; cp0_addr = 5'd11; cp0_wdata = 32'd5;
      @(negedge Clk);
      idle(); cp0_we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_8001;
      @(negedge Clk);
      idle();
      hit = 1'b0;
      for (int i = 0; i < 30 && !hit; i++) begin
        #1;
        if (exp_in) hit = 1'b1;
        @(negedge Clk);
      end
      chk("timer_int", 32'(hit), 32'd1);
      idle(); eret_M = 1'b1; cp0_we = 1'b0;
      @(negedge Clk);
    end
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      idle();
      Reset      = ($urandom_range(0, 299) == 0);
      pc_M       = $urandom & 32'hFFFF_FFFC;
      bd_M       = $urandom_range(0, 1);
      exc_code_M = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      eret_M     = ($urandom_range(0, 5) == 0);
      hw_int     = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
      cp0_we     = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 6))
        0: cp0_addr = 5'd9;
        1: cp0_addr = 5'd11;
        2: cp0_addr = 5'd12;
        3: cp0_addr = 5'd13;
        4: cp0_addr = 5'd14;
        5: cp0_addr = 5'd15;
        default: cp0_addr = 5'($urandom);
      endcase
      cp0_wdata  = $urandom;
      if (cp0_addr == 5'd12 && ($urandom_range(0, 1) == 0)) cp0_wdata[1] = 1'b0;
      @(negedge Clk);
    end

    idle();
    @(negedge Clk);
    @(negedge Clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
